// File: rtl/itrx_aib_phy_tap.sv
// ---------------------------------------------------------------------------
// itrx_aib_phy_tap
//   IEEE 1149.1 TAP controller for the AIB PHY. Runs the 16-state TAP FSM,
//   owns the instruction register and drives the latched instruction to the
//   AIB jtag_* decoder. It provides the IDCODE and BYPASS data registers and
//   steers Shift-DR traffic to the external AIB boundary-scan chain.
//
// Ports:
//   tck            in   JTAG test clock (state on rising edge, tdo on falling)
//   reset_n        in   asynchronous active-low reset
//   tms, tdi       in   test mode select / test data in, sampled on rising tck
//   tdo, tdo_en    out  serial data out and its enable, updated on falling tck
//   ir_latched     out  current instruction for the AIB decoder
//   bscan_sel      out  current instruction selects the external chain
//   bscan_capture  out  Capture-DR strobe for the external chain
//   bscan_shift    out  Shift-DR strobe for the external chain
//   bscan_update   out  Update-DR strobe for the external chain
//   bscan_tdi      out  tdi passed through to the external chain
//   bscan_tdo      in   serial return from the external chain
// ---------------------------------------------------------------------------
module itrx_aib_phy_tap #(
  parameter int                        LATCHED_IR_WID = 7,
  parameter logic [31:0]               IDCODE_VAL     = 32'h1000_0AB5,
  parameter logic [LATCHED_IR_WID-1:0] IR_CAPTURE     = LATCHED_IR_WID'(7'b000_0001)
) (
  input  logic                      tck,
  input  logic                      reset_n,
  input  logic                      tms,
  input  logic                      tdi,
  output logic                      tdo,
  output logic                      tdo_en,
  output logic [LATCHED_IR_WID-1:0] ir_latched,
  output logic                      bscan_sel,
  output logic                      bscan_capture,
  output logic                      bscan_shift,
  output logic                      bscan_update,
  output logic                      bscan_tdi,
  input  logic                      bscan_tdo
);

  localparam logic [LATCHED_IR_WID-1:0] IR_EXTEST        = LATCHED_IR_WID'(7'h00);
  localparam logic [LATCHED_IR_WID-1:0] IR_IDCODE        = LATCHED_IR_WID'(7'h01);
  localparam logic [LATCHED_IR_WID-1:0] IR_SAMPLE_PRELD  = LATCHED_IR_WID'(7'h02);
  localparam logic [LATCHED_IR_WID-1:0] IR_AIB_SHIFT_EN  = LATCHED_IR_WID'(7'h0C);
  localparam logic [LATCHED_IR_WID-1:0] IR_AIB_INTEST_EN = LATCHED_IR_WID'(7'h16);

  typedef enum logic [3:0] {
    S_TLR,    S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_t;

  tap_state_t                r_state;
  tap_state_t                w_state_next;
  logic [LATCHED_IR_WID-1:0] r_ir_shift;
  logic [LATCHED_IR_WID-1:0] r_ir_latched;
  logic [31:0]               r_idcode;
  logic                      r_bypass;
  logic                      r_tdo;
  logic                      r_tdo_en;

  logic                      w_sel_idcode;
  logic                      w_sel_bscan;
  logic                      w_sel_bypass;
  logic                      w_tdo_next;
  logic                      w_shifting;

  // -------------------------------------------------------------------------
  // TAP state machine
  // -------------------------------------------------------------------------
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_TLR:    w_state_next = tms ? S_TLR    : S_RTI;
      S_RTI:    w_state_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_state_next = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_state_next = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_state_next = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_state_next = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_state_next = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_state_next = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_state_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_state_next = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_state_next = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_state_next = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_state_next = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_state_next = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_state_next = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_state_next = tms ? S_SEL_DR : S_RTI;
      default:  w_state_next = S_TLR;
    endcase
  end

  // -------------------------------------------------------------------------
  // Instruction register: shift stage plus latched copy. The latched copy
  // only moves in Update-IR or TLR, so the DR selection is frozen during
  // any DR scan.
  // -------------------------------------------------------------------------
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_shift   <= '0;
      r_ir_latched <= IR_IDCODE;
    end else begin
      if (r_state == S_CAP_IR) begin
        r_ir_shift <= IR_CAPTURE;
      end else if (r_state == S_SH_IR) begin
        r_ir_shift <= {tdi, r_ir_shift[LATCHED_IR_WID-1:1]};
      end

      if (r_state == S_TLR) begin
        r_ir_latched <= IR_IDCODE;
      end else if (r_state == S_UPD_IR) begin
        r_ir_latched <= r_ir_shift;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Instruction decode
  // -------------------------------------------------------------------------
  assign w_sel_idcode = (r_ir_latched == IR_IDCODE);
  assign w_sel_bscan  = (r_ir_latched == IR_EXTEST)       ||
                        (r_ir_latched == IR_SAMPLE_PRELD) ||
                        (r_ir_latched == IR_AIB_SHIFT_EN) ||
                        (r_ir_latched == IR_AIB_INTEST_EN);
  assign w_sel_bypass = !w_sel_idcode && !w_sel_bscan;

  // -------------------------------------------------------------------------
  // Internal data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_idcode <= '0;
      r_bypass <= 1'b0;
    end else begin
      if (w_sel_idcode) begin
        if (r_state == S_CAP_DR) begin
          r_idcode <= IDCODE_VAL;
        end else if (r_state == S_SH_DR) begin
          r_idcode <= {tdi, r_idcode[31:1]};
        end
      end
      if (w_sel_bypass) begin
        if (r_state == S_CAP_DR) begin
          r_bypass <= 1'b0;
        end else if (r_state == S_SH_DR) begin
          r_bypass <= tdi;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // tdo mux and falling-edge output stage; tdo holds outside the Shift states
  // -------------------------------------------------------------------------
  assign w_shifting = (r_state == S_SH_IR) || (r_state == S_SH_DR);

  always_comb begin
    w_tdo_next = r_tdo;
    if (r_state == S_SH_IR) begin
      w_tdo_next = r_ir_shift[0];
    end else if (r_state == S_SH_DR) begin
      if (w_sel_idcode) begin
        w_tdo_next = r_idcode[0];
      end else if (w_sel_bscan) begin
        w_tdo_next = bscan_tdo;
      end else begin
        w_tdo_next = r_bypass;
      end
    end
  end

  always_ff @(negedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_next;
      r_tdo_en <= w_shifting;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tdo           = r_tdo;
  assign tdo_en        = r_tdo_en;
  assign ir_latched    = r_ir_latched;
  assign bscan_sel     = w_sel_bscan;
  assign bscan_capture = w_sel_bscan && (r_state == S_CAP_DR);
  assign bscan_shift   = w_sel_bscan && (r_state == S_SH_DR);
  assign bscan_update  = w_sel_bscan && (r_state == S_UPD_DR);
  assign bscan_tdi     = tdi;

endmodule

// File: tb/tb_itrx_aib_phy_tap.sv
module tb_itrx_aib_phy_tap;

  logic       tck = 1'b0;
  logic       reset_n;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [6:0] ir_latched;
  logic       bscan_sel;
  logic       bscan_capture;
  logic       bscan_shift;
  logic       bscan_update;
  logic       bscan_tdi;
  logic       bscan_tdo;

  int n_checks = 0;
  int n_errors = 0;

  itrx_aib_phy_tap dut (
    .tck           (tck),
    .reset_n       (reset_n),
    .tms           (tms),
    .tdi           (tdi),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .ir_latched    (ir_latched),
    .bscan_sel     (bscan_sel),
    .bscan_capture (bscan_capture),
    .bscan_shift   (bscan_shift),
    .bscan_update  (bscan_update),
    .bscan_tdi     (bscan_tdi),
    .bscan_tdo     (bscan_tdo)
  );

  always #5 tck = ~tck;

  // One TAP cycle: drive tms/tdi while tck is low, take the rising edge,
  // then settle just after the falling edge so tdo reflects the new state.
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic load_ir(input logic [6:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(i == 6, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    tms       = 1'b1;
    tdi       = 1'b0;
    bscan_tdo = 1'b0;
    repeat (3) @(negedge tck);
    #1;
    reset_n = 1'b1;
    n_checks++;
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL reset_ir: got %0h expected 01", ir_latched);
    end
    n_checks++;
    if ({tdo, tdo_en} !== 2'b00) begin
      n_errors++; $display("FAIL reset_tdo: got tdo=%0b tdo_en=%0b expected 0 0", tdo, tdo_en);
    end
    n_checks++;
    if ({bscan_sel, bscan_capture, bscan_shift, bscan_update} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_bscan: got %b expected 0000",
                           {bscan_sel, bscan_capture, bscan_shift, bscan_update});
    end
    tdi = 1'b1;
    #1;
    n_checks++;
    if (bscan_tdi !== 1'b1) begin
      n_errors++; $display("FAIL bscan_tdi: got %0b expected 1", bscan_tdi);
    end
    tdi = 1'b0;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_idcode();
    logic [31:0] id;
    id = 32'h1000_0AB5;
    step(1'b1, 1'b0);   // TLR stays
    step(1'b0, 1'b0);   // RTI
    step(1'b1, 1'b0);   // SelDR
    step(1'b0, 1'b0);   // CapDR
    step(1'b0, 1'b0);   // ShDR
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (tdo_en !== 1'b1 || tdo !== id[i]) begin
        n_errors++; $display("FAIL idcode_bit%0d: got tdo=%0b tdo_en=%0b expected %0b 1",
                             i, tdo, tdo_en, id[i]);
      end
      step(i == 31, 1'b0);
    end
    n_checks++;
    if (tdo_en !== 1'b0) begin
      n_errors++; $display("FAIL idcode_tdo_en_end: got %0b expected 0", tdo_en);
    end
    step(1'b1, 1'b0);   // UpdDR
    step(1'b0, 1'b0);   // RTI
    $display("test_idcode done");
  endtask

  task automatic test_ir_load();
    logic [6:0] v;
    logic [6:0] cap;
    v   = 7'h0C;
    cap = 7'h01;
    step(1'b1, 1'b0);   // SelDR
    step(1'b1, 1'b0);   // SelIR
    step(1'b0, 1'b0);   // CapIR
    step(1'b0, 1'b0);   // ShIR
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (tdo_en !== 1'b1 || tdo !== cap[i]) begin
        n_errors++; $display("FAIL ir_capture_bit%0d: got tdo=%0b tdo_en=%0b expected %0b 1",
                             i, tdo, tdo_en, cap[i]);
      end
      step(i == 6, v[i]);
    end
    n_checks++;             // Ex1IR
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL ir_ex1: got %0h expected 01", ir_latched);
    end
    step(1'b0, 1'b0);       // PauIR
    n_checks++;
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL ir_pause: got %0h expected 01", ir_latched);
    end
    step(1'b1, 1'b0);       // Ex2IR
    step(1'b1, 1'b0);       // UpdIR
    n_checks++;
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL ir_upd: got %0h expected 01", ir_latched);
    end
    step(1'b0, 1'b0);       // RTI
    n_checks++;
    if (ir_latched !== 7'h0C || bscan_sel !== 1'b1) begin
      n_errors++; $display("FAIL ir_loaded: got ir=%0h sel=%0b expected 0c 1", ir_latched, bscan_sel);
    end
    $display("test_ir_load done");
  endtask

  task automatic test_bypass();
    logic [3:0] pat;
    logic [3:0] exp;
    pat = 4'b1011;          // bits 0..3 = 1,1,0,1
    exp = 4'b0110;          // bits 0..3 = 0,1,1,0
    load_ir(7'h7F);
    n_checks++;
    if (ir_latched !== 7'h7F || bscan_sel !== 1'b0) begin
      n_errors++; $display("FAIL bypass_ir: got ir=%0h sel=%0b expected 7f 0", ir_latched, bscan_sel);
    end
    step(1'b1, 1'b0);       // SelDR
    step(1'b0, 1'b0);       // CapDR
    n_checks++;
    if (bscan_capture !== 1'b0) begin
      n_errors++; $display("FAIL bypass_capture: got %0b expected 0", bscan_capture);
    end
    step(1'b0, 1'b0);       // ShDR
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tdo !== exp[i] || bscan_shift !== 1'b0) begin
        n_errors++; $display("FAIL bypass_bit%0d: got tdo=%0b shift=%0b expected %0b 0",
                             i, tdo, bscan_shift, exp[i]);
      end
      step(i == 3, pat[i]);
    end
    step(1'b1, 1'b0);       // UpdDR
    n_checks++;
    if (bscan_update !== 1'b0) begin
      n_errors++; $display("FAIL bypass_update: got %0b expected 0", bscan_update);
    end
    step(1'b0, 1'b0);       // RTI
    $display("test_bypass done");
  endtask

  task automatic test_bscan();
    logic [2:0] ret;
    int n_cap;
    int n_sh;
    int n_upd;
    ret   = 3'b101;
    n_cap = 0;
    n_sh  = 0;
    n_upd = 0;
    load_ir(7'h02);
    n_checks++;
    if (bscan_sel !== 1'b1) begin
      n_errors++; $display("FAIL bscan_sel: got %0b expected 1", bscan_sel);
    end
    step(1'b1, 1'b0);       // SelDR
    n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
    step(1'b0, 1'b0);       // CapDR
    n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
    for (int i = 0; i < 3; i++) begin
      bscan_tdo = ret[i];
      step(1'b0, 1'b0);     // ShDR
      n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
      n_checks++;
      if (tdo !== ret[i]) begin
        n_errors++; $display("FAIL bscan_tdo_bit%0d: got %0b expected %0b", i, tdo, ret[i]);
      end
      bscan_tdo = ~ret[i];  // must not be seen until the next falling edge
    end
    step(1'b1, 1'b0);       // Ex1DR
    n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
    step(1'b1, 1'b0);       // UpdDR
    n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
    step(1'b0, 1'b0);       // RTI
    n_cap += bscan_capture; n_sh += bscan_shift; n_upd += bscan_update;
    n_checks++;
    if (n_cap != 1 || n_sh != 3 || n_upd != 1) begin
      n_errors++; $display("FAIL bscan_strobes: got cap=%0d sh=%0d upd=%0d expected 1 3 1",
                           n_cap, n_sh, n_upd);
    end
    $display("test_bscan done");
  endtask

  task automatic test_reset_mid_dr();
    step(1'b1, 1'b0);       // SelDR
    step(1'b0, 1'b0);       // CapDR
    step(1'b0, 1'b0);       // ShDR
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ir_latched !== 7'h01 || tdo_en !== 1'b0 || bscan_shift !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_dr: got ir=%0h tdo_en=%0b shift=%0b expected 01 0 0",
                           ir_latched, tdo_en, bscan_shift);
    end
    reset_n = 1'b1;
    #1;
    $display("test_reset_mid_dr done");
  endtask

  task automatic test_tms_reset();
    logic [6:0] v;
    v = 7'h0C;
    step(1'b0, 1'b0);       // RTI
    step(1'b1, 1'b0);       // SelDR
    step(1'b1, 1'b0);       // SelIR
    step(1'b0, 1'b0);       // CapIR
    step(1'b0, 1'b0);       // ShIR
    for (int i = 0; i < 7; i++) step(i == 6, v[i]);
    step(1'b0, 1'b0);       // PauIR
    repeat (5) step(1'b1, 1'b0);   // -> TLR
    step(1'b1, 1'b0);       // TLR forces IDCODE
    n_checks++;
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL tms_reset_ir: got %0h expected 01", ir_latched);
    end
    step(1'b0, 1'b0);       // RTI
    step(1'b1, 1'b0);       // SelDR
    step(1'b0, 1'b0);       // CapDR
    step(1'b0, 1'b0);       // ShDR
    n_checks++;
    if (tdo_en !== 1'b1 || tdo !== 1'b1) begin
      n_errors++; $display("FAIL tms_reset_path: got tdo=%0b tdo_en=%0b expected 1 1", tdo, tdo_en);
    end
    step(1'b1, 1'b0);       // Ex1DR
    step(1'b1, 1'b0);       // UpdDR
    step(1'b0, 1'b0);       // RTI
    $display("test_tms_reset done");
  endtask

  task automatic test_reset_mid_ir();
    logic [6:0] v;
    v = 7'h0E;
    step(1'b1, 1'b0);       // SelDR
    step(1'b1, 1'b0);       // SelIR
    step(1'b0, 1'b0);       // CapIR
    step(1'b0, 1'b0);       // ShIR
    for (int i = 0; i < 4; i++) step(1'b0, v[i]);
    n_checks++;
    if (tdo_en !== 1'b1) begin
      n_errors++; $display("FAIL mid_ir_shifting: got tdo_en=%0b expected 1", tdo_en);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ir_latched !== 7'h01 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_ir: got ir=%0h tdo=%0b tdo_en=%0b expected 01 0 0",
                           ir_latched, tdo, tdo_en);
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0);       // TLR -> RTI
    n_checks++;
    if (ir_latched !== 7'h01) begin
      n_errors++; $display("FAIL reset_mid_ir_after: got %0h expected 01", ir_latched);
    end
    $display("test_reset_mid_ir done");
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_load();
    test_bypass();
    test_bscan();
    test_reset_mid_dr();
    test_tms_reset();
    test_reset_mid_ir();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
